rf_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 32 x 64-bit register file. Two write-back requesters (e.g. ALU and load unit) share the register file's single write port. The block applies round-robin arbitration, registers the winning write, drives RD/WriteData/RegWrite, and suppresses writes to x0. It sits between the execute/memory stages and the register file, and optionally forwards the in-flight write onto the read ports.

---
 rtl/rf_wb_arbiter_pkg.sv | 34 +++
 rtl/rf_wb_arbiter_rr_arb2.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-back arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   REG_ZERO                : index of the hard-wired zero register
//   wb_req_t                : one write-back request {rd, data}
//   rr_pick                 : 2-way round-robin grant decode
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  // A lone requester always wins; on a tie the prio bit names the winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = prio ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Holds the prio bit and decodes the grant.
// Ports:
//   clk   : clock, state updates on rising edge
//   reset : synchronous active-low reset (0 = reset asserted)
//   req   : request vector, bit N = requester N valid
//   gnt   : one-hot grant, combinational, forced to 0 while in reset
// ---------------------------------------------------------------------------
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  // Grant decode. Nothing is accepted while reset is held so a requester
  // presenting a write during reset keeps it until reset releases.
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = rr_pick(req, prio);
    end
  end

  // After a grant the loser gets priority next time; with no grant the
  // priority is left alone so alternation resumes where it stopped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (gnt[0]) begin
      prio <= 1'b1;
    end else if (gnt[1]) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Write-back arbiter/sequencer in front of the 32 x 64-bit register file.
// Two requesters share the single write port; the winner is registered in
// a one-entry pending stage that drives the write port the next cycle.
// Writes to x0 handshake normally but never raise RegWrite.
//
// Build option: define RFARB_BYPASS_EN to forward the pending write onto
// the read data outputs; otherwise rdataN passes rf_rdataN straight through.
//
// Ports:
//   clk, reset               : clock, synchronous active-low reset
//   wbN_valid/rd/data        : requester N write request
//   wbN_ready                : requester N accepted this cycle
//   rf_RD/WriteData/RegWrite : register-file write port
//   rs1, rs2                 : read indices as presented to the register file
//   rf_rdata1, rf_rdata2     : register-file read data
//   rdata1, rdata2           : read data delivered to the datapath
//   conflict_cnt             : saturating count of cycles with both valid
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DEF_DATA_W,
  parameter int ADDR_W = rf_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic [ADDR_W-1:0] rf_RD,
  output logic [DATA_W-1:0] rf_WriteData,
  output logic              rf_RegWrite,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [15:0]       conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [1:0]        gnt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_rd;
  logic [DATA_W-1:0] pend_data;
  logic              pend_live;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({wb1_valid, wb0_valid}),
    .gnt   (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // Pending stage: loads whichever request won this cycle. Index/data are
  // only reloaded on a grant; pend_valid alone marks them meaningful.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= |gnt;
      if (gnt[0]) begin
        pend_rd   <= wb0_rd;
        pend_data <= wb0_data;
      end else if (gnt[1]) begin
        pend_rd   <= wb1_rd;
        pend_data <= wb1_data;
      end
    end
  end

  // The pending entry is qualified by reset so a write caught by a reset
  // in its drive cycle is dropped instead of reaching the register file.
  assign pend_live    = reset && pend_valid;
  assign rf_RegWrite  = pend_live && (pend_rd != ZERO_IDX);
  assign rf_RD        = reset ? pend_rd   : '0;
  assign rf_WriteData = reset ? pend_data : '0;

`ifdef RFARB_BYPASS_EN
  // Forward the write the register file has not captured yet. x0 is never
  // forwarded so reads of x0 always come from the register file.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    if (pend_live && (rs1 == pend_rd) && (rs1 != ZERO_IDX)) begin
      rdata1 = pend_data;
    end
    if (pend_live && (rs2 == pend_rd) && (rs2 != ZERO_IDX)) begin
      rdata2 = pend_data;
    end
  end
`else
  // Pure pass-through; the read indices are not needed in this build.
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign rdata1    = rf_rdata1;
  assign rdata2    = rf_rdata2;
`endif

  // Contention counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (wb0_valid && wb1_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of arbitration, the
// pending write and the register file contents.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0Valid, wb1Valid;
  logic [4:0]  wb0Rd, wb1Rd;
  logic [63:0] wb0Data, wb1Data;
  logic        wb0Ready, wb1Ready;
  logic [4:0]  rfRD;
  logic [63:0] rfWriteData;
  logic        rfRegWrite;
  logic [4:0]  rs1, rs2;
  logic [63:0] rfRdata1, rfRdata2;
  logic [63:0] rdata1, rdata2;
  logic [15:0] conflictCnt;

  int assertCount = 0;
  int failCount   = 0;

  // Register file the DUT writes into; the bench owns it as the environment.
  logic [63:0] envRegs [32];

  // Reference model state.
  logic [63:0] mRegs [32];
  bit          mPendValid;
  logic [4:0]  mPendRd;
  logic [63:0] mPendData;
  int          mTurn;
  int          mCnt;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb0_valid    (wb0Valid),
    .wb0_rd       (wb0Rd),
    .wb0_data     (wb0Data),
    .wb0_ready    (wb0Ready),
    .wb1_valid    (wb1Valid),
    .wb1_rd       (wb1Rd),
    .wb1_data     (wb1Data),
    .wb1_ready    (wb1Ready),
    .rf_RD        (rfRD),
    .rf_WriteData (rfWriteData),
    .rf_RegWrite  (rfRegWrite),
    .rs1          (rs1),
    .rs2          (rs2),
    .rf_rdata1    (rfRdata1),
    .rf_rdata2    (rfRdata2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .conflict_cnt (conflictCnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Environment register file: combinational read, capture on rising edge.
  assign rfRdata1 = envRegs[rs1];
  assign rfRdata2 = envRegs[rs2];

  always @(posedge clk) begin
    if (rfRegWrite) envRegs[rfRD] <= rfWriteData;
  end

  function automatic logic [63:0] initVal(input int i);
    return (i == 0) ? 64'd0 : 64'h0000_0000_0000_1000 + 64'(i);
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Which requester the model grants this cycle: -1 none, else the index.
  function automatic int modelGrant();
    if (!reset) return -1;
    if (wb0Valid && wb1Valid) return mTurn;
    if (wb0Valid) return 0;
    if (wb1Valid) return 1;
    return -1;
  endfunction

  function automatic logic [63:0] modelRead(input logic [4:0] rs);
`ifdef RFARB_BYPASS_EN
    if (reset && mPendValid && rs == mPendRd && rs != 5'd0) return mPendData;
`endif
    return mRegs[rs];
  endfunction

  // Advance the model by one clock edge using the inputs of that cycle.
  task automatic modelStep();
    int g;
    g = modelGrant();
    if (!reset) begin
      mPendValid = 1'b0;
      mTurn      = 0;
      mCnt       = 0;
    end else begin
      if (mPendValid && mPendRd != 5'd0) mRegs[mPendRd] = mPendData;
      if (wb0Valid && wb1Valid && mCnt != 65535) mCnt++;
      if (g == 0) begin
        mPendValid = 1'b1; mPendRd = wb0Rd; mPendData = wb0Data; mTurn = 1;
      end else if (g == 1) begin
        mPendValid = 1'b1; mPendRd = wb1Rd; mPendData = wb1Data; mTurn = 0;
      end else begin
        mPendValid = 1'b0;
      end
    end
  endtask

  // One cycle: drive on the falling edge, check just before the rising
  // edge, then step the model across the edge.
  task automatic applyStimulus(input logic r,
                               input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                               input logic [4:0] s1, input logic [4:0] s2);
    int  g;
    bit  expWrite;
    @(negedge clk);
    reset = r;
    wb0Valid = v0; wb0Rd = a0; wb0Data = d0;
    wb1Valid = v1; wb1Rd = a1; wb1Data = d1;
    rs1 = s1; rs2 = s2;
    #2;
    g = modelGrant();
    expWrite = reset && mPendValid && (mPendRd != 5'd0);
    checkOutput("wb0_ready", 64'(wb0Ready), 64'(g == 0));
    checkOutput("wb1_ready", 64'(wb1Ready), 64'(g == 1));
    checkOutput("rf_RegWrite", 64'(rfRegWrite), 64'(expWrite));
    if (expWrite) begin
      checkOutput("rf_RD", 64'(rfRD), 64'(mPendRd));
      checkOutput("rf_WriteData", rfWriteData, mPendData);
    end
    if (!reset) begin
      checkOutput("rf_RD_reset", 64'(rfRD), 64'd0);
      checkOutput("rf_WriteData_reset", rfWriteData, 64'd0);
    end
    checkOutput("rdata1", rdata1, modelRead(rs1));
    checkOutput("rdata2", rdata2, modelRead(rs2));
    checkOutput("conflict_cnt", 64'(conflictCnt), 64'(mCnt));
    @(posedge clk);
    modelStep();
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    applyStimulus(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, s1, s2);
  endtask

  // Main sequence: directed scenarios, then random traffic.
  initial begin
    for (int i = 0; i < 32; i++) begin
      envRegs[i] = initVal(i);
      mRegs[i]   = initVal(i);
    end
    mPendValid = 1'b0; mPendRd = 5'd0; mPendData = 64'd0; mTurn = 0; mCnt = 0;
    reset = 1'b0;
    wb0Valid = 1'b0; wb1Valid = 1'b0;
    wb0Rd = 5'd0; wb1Rd = 5'd0; wb0Data = 64'd0; wb1Data = 64'd0;
    rs1 = 5'd0; rs2 = 5'd0;

    // Bring the design into a known state before any checking.
    @(posedge clk);

    $display("[TB] reset with both requesters valid");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
    #1;
    checkOutput("reset_conflict_cnt", 64'(conflictCnt), 64'd0);

    $display("[TB] single write to x29");
    applyStimulus(1'b1, 1'b1, 5'd29, 64'd23, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd29, 5'd0);
    #1;
    checkOutput("single_rdata1", rdata1, 64'd23);

    $display("[TB] contention for four cycles");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 5'd5, 64'hA, 1'b1, 5'd6, 64'hB, 5'd5, 5'd6);
    idle(5'd5, 5'd6);
    #1;
    checkOutput("contention_conflict_cnt", 64'(conflictCnt), 64'd4);
    idle(5'd5, 5'd6);
    #1;
    checkOutput("contention_last_rd5", rdata1, 64'hA);
    checkOutput("contention_last_rd6", rdata2, 64'hB);

    $display("[TB] write to x0");
    applyStimulus(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    #1;
    checkOutput("x0_rdata1", rdata1, 64'd0);

    $display("[TB] read of a write still in flight");
    applyStimulus(1'b1, 1'b1, 5'd15, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    @(negedge clk);
    rs2 = 5'd15; wb0Valid = 1'b0;
    #2;
`ifdef RFARB_BYPASS_EN
    checkOutput("bypass_rdata2", rdata2, 64'h1234);
`else
    checkOutput("bypass_rdata2", rdata2, initVal(15));
`endif
    @(posedge clk);
    modelStep();
    idle(5'd0, 5'd15);

    $display("[TB] reset while a write is pending");
    applyStimulus(1'b1, 1'b1, 5'd25, 64'd7, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd25, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd25, 5'd0);
    idle(5'd25, 5'd0);
    #1;
    checkOutput("midreset_rdata1", rdata1, initVal(25));

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    {$urandom, $urandom},
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
